// File: rtl/stream_demux_1to4.sv
// stream_demux_1to4
// Registered 1-to-4 stream demultiplexer with a valid/ready handshake.
// Each accepted word carries a 3-bit select code. Codes 0..3 route the word
// to the matching output channel through a single-entry holding register.
// Codes 4..7 are accepted and dropped. Each dropped word raises a one-cycle
// pulse and increments a saturating counter.
module stream_demux_1to4 #(
  parameter int DATA_W = 8,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic              drop_pulse,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [3:0]          valid_q, valid_d;
  logic                drop_pulse_q, drop_pulse_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic                out_fire;
  logic                accept;
  logic                sel_invalid;

  // Handshake terms.
  // in_ready depends only on the state and the consumer readies.
  // It never depends on in_valid.
  always_comb begin
    out_fire    = |(valid_q & out_ready);
    in_ready    = (state_q == EMPTY) | out_fire;
    accept      = in_valid & in_ready;
    sel_invalid = in_sel[2];
  end

  // Next-state logic: drain on fire, then load or drop on accept.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    valid_d      = valid_q;
    drop_pulse_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;

    // A fire frees the slot.
    // A valid accept in the same cycle refills the slot below.
    if (out_fire) begin
      state_d = EMPTY;
      valid_d = 4'b0000;
    end

    if (accept) begin
      if (sel_invalid) begin
        // Dropped word: leave the holding register untouched.
        drop_pulse_d = 1'b1;
        if (drop_cnt_q != {DROP_W{1'b1}}) begin
          drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
      end else begin
        state_d = FULL;
        data_d  = in_data;
        valid_d = 4'b0001 << in_sel[1:0];
      end
    end
  end

  // State and output registers.
  // An asynchronous reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      valid_q      <= 4'b0000;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Drive the outputs directly from the registers.
  always_comb begin
    out_data   = data_q;
    out_valid  = valid_q;
    drop_pulse = drop_pulse_q;
    drop_cnt   = drop_cnt_q;
  end

endmodule
